im_load_fetch_ctrl: RTL

Controller that owns the single port of the instruction memory. It shares that port between the CPU fetch stage and a host program loader. After reset it holds the CPU in stall until a program image has been streamed into IM. It then grants CPU fetches, with a registered one-cycle read response. A later reload request drains any in-flight fetch, re-stalls the CPU and rewrites IM.

---
 rtl/im_load_fetch_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/im_load_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// im_load_fetch_ctrl
//
// Owns the single port of the instruction memory (IM) and shares it between
// the CPU fetch stage and a host program loader. Out of reset the CPU is held
// in stall until a program image has been streamed into IM. After that, CPU
// fetches are granted with a registered one-cycle read response. A later
// reload request drains any in-flight fetch, re-stalls the CPU and rewrites IM.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ld_start/base/len     loader request (base/len sampled on ld_start)
//   ld_valid/data/ready   loader word stream
//   ld_done, ld_err       one-cycle pulses: load finished / request rejected
//   if_req/addr/gnt       CPU fetch request and grant
//   if_rvalid/rdata/err   CPU fetch response, one cycle after the grant
//   cpu_stall             CPU must hold its PC
//   im_we/addr/wdata      IM port (write enable, byte address, write data)
//   im_rdata              IM combinational read data
// -----------------------------------------------------------------------------
module im_load_fetch_ctrl #(
  parameter int                    ARCH_WIDTH   = 32,
  parameter int                    IM_WIDTH     = 32,
  parameter logic [ARCH_WIDTH-1:0] IM_BASE_ADDR = 'h0000_3000,
  parameter int                    IM_SIZE      = 1024,
  parameter int                    LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [ARCH_WIDTH-1:0] ld_base,
  input  logic [LEN_WIDTH-1:0]  ld_len,
  input  logic                  ld_valid,
  input  logic [IM_WIDTH-1:0]   ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_err,
  input  logic                  if_req,
  input  logic [ARCH_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [0:IM_WIDTH-1]   if_rdata,
  output logic                  if_err,
  output logic                  cpu_stall,
  output logic                  im_we,
  output logic [ARCH_WIDTH-1:0] im_addr,
  output logic [IM_WIDTH-1:0]   im_wdata,
  input  logic [IM_WIDTH-1:0]   im_rdata
);

  // Range arithmetic is carried at a width that cannot wrap for any
  // combination of base address and word count.
  localparam int CHK_W = ARCH_WIDTH + LEN_WIDTH + 2;
  localparam logic [CHK_W-1:0] IM_BYTES = CHK_W'(4 * IM_SIZE);
  localparam logic [CHK_W-1:0] IM_END   = CHK_W'(IM_BASE_ADDR) + IM_BYTES;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_LOAD,
    ST_DONE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                state_reg;
  logic [ARCH_WIDTH-1:0] base_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  cnt_reg;

  logic                  cpu_stall_reg;
  logic                  ld_ready_reg;
  logic                  ld_done_reg;
  logic                  ld_err_reg;
  logic                  if_rvalid_reg;
  logic                  if_err_reg;
  logic [IM_WIDTH-1:0]   if_rdata_reg;

  logic                  ld_ok;
  logic [CHK_W-1:0]      ld_end;
  logic                  fetch_bad;
  logic                  beat;
  logic                  last_beat;

  // Load request validation: non-empty, word aligned, and the whole image
  // [base, base + 4*len) must fit inside IM. The end offset is only meaningful
  // when base >= IM_BASE_ADDR, which is checked alongside it.
  always_comb begin
    ld_end = CHK_W'(ld_base) - CHK_W'(IM_BASE_ADDR) + CHK_W'({ld_len, 2'b00});
    ld_ok  = (ld_len != '0) &&
             (ld_base[1:0] == 2'b00) &&
             (ld_base >= IM_BASE_ADDR) &&
             (ld_end <= IM_BYTES);
  end

  // Fetches outside IM or not word aligned are still granted but answered
  // with an error and zero data.
  always_comb begin
    fetch_bad = (if_addr[1:0] != 2'b00) ||
                (if_addr < IM_BASE_ADDR) ||
                (CHK_W'(if_addr) >= IM_END);
  end

  assign beat      = (state_reg == ST_LOAD) && ld_valid;
  assign last_beat = (cnt_reg == len_reg - LEN_WIDTH'(1));

  // The IM port is steered combinationally so a beat writes IM at the same
  // clock edge, and a granted fetch reads IM in its grant cycle.
  assign if_gnt   = (state_reg == ST_RUN) && if_req;
  assign im_we    = beat;
  assign im_wdata = ld_data;

  always_comb begin
    im_addr = IM_BASE_ADDR;
    case (state_reg)
      ST_LOAD: im_addr = base_reg + ARCH_WIDTH'({cnt_reg, 2'b00});
      ST_RUN:  im_addr = if_addr;
      default: im_addr = IM_BASE_ADDR;
    endcase
  end

  // Control FSM with registered status outputs. Each registered output is
  // loaded with the value that belongs to the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_BOOT;
      base_reg      <= IM_BASE_ADDR;
      len_reg       <= '0;
      cnt_reg       <= '0;
      cpu_stall_reg <= 1'b1;
      ld_ready_reg  <= 1'b0;
      ld_done_reg   <= 1'b0;
      ld_err_reg    <= 1'b0;
      if_rvalid_reg <= 1'b0;
      if_err_reg    <= 1'b0;
      if_rdata_reg  <= '0;
    end else begin
      ld_done_reg   <= 1'b0;
      ld_err_reg    <= 1'b0;

      // Response path: exactly one response per grant, including a fetch
      // granted in the same cycle as an accepted reload (answered in DRAIN).
      if_rvalid_reg <= if_gnt;
      if_err_reg    <= if_gnt && fetch_bad;
      if (if_gnt) begin
        if_rdata_reg <= fetch_bad ? '0 : im_rdata;
      end

      case (state_reg)
        ST_BOOT: begin
          if (ld_start) begin
            if (ld_ok) begin
              state_reg    <= ST_LOAD;
              base_reg     <= ld_base;
              len_reg      <= ld_len;
              cnt_reg      <= '0;
              ld_ready_reg <= 1'b1;
            end else begin
              ld_err_reg   <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // A new ld_start while loading is silently ignored.
          if (beat) begin
            cnt_reg <= cnt_reg + LEN_WIDTH'(1);
            if (last_beat) begin
              state_reg    <= ST_DONE;
              ld_ready_reg <= 1'b0;
              ld_done_reg  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_reg     <= ST_RUN;
          cpu_stall_reg <= 1'b0;
        end

        ST_RUN: begin
          if (ld_start) begin
            if (ld_ok) begin
              state_reg     <= ST_DRAIN;
              cpu_stall_reg <= 1'b1;
              base_reg      <= ld_base;
              len_reg       <= ld_len;
              cnt_reg       <= '0;
            end else begin
              ld_err_reg    <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          state_reg    <= ST_LOAD;
          ld_ready_reg <= 1'b1;
        end

        default: begin
          state_reg     <= ST_BOOT;
          cpu_stall_reg <= 1'b1;
          ld_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_stall_reg;
  assign ld_ready  = ld_ready_reg;
  assign ld_done   = ld_done_reg;
  assign ld_err    = ld_err_reg;
  assign if_rvalid = if_rvalid_reg;
  assign if_err    = if_err_reg;
  assign if_rdata  = if_rdata_reg;

endmodule
